// File: rtl/dcp_recover_if.sv
// Pixel bus for the dehaze recovery stage.
// The hazy pixel, its transmittance and the frame A estimate arrive on i_*,
// and the recovered pixel leaves on o_*.
// Handshake: i_data_valid qualifies i_r/i_g/i_b/i_transmittance in the cycle it is high.
// There is no ready: the consumer must accept every cycle, and the stage never stalls.
// o_data_valid qualifies o_r/o_g/o_b in the same way.
interface dcp_recover_if;
    logic       i_data_valid;
    logic       i_vs;
    logic       i_hs;
    logic [7:0] i_r;
    logic [7:0] i_g;
    logic [7:0] i_b;
    logic [7:0] i_transmittance;
    logic [7:0] i_atmos;
    logic [7:0] o_r;
    logic [7:0] o_g;
    logic [7:0] o_b;
    logic       o_data_valid;
    logic       o_vs;
    logic       o_hs;
    logic [7:0] o_atmos_used;

    // Upstream side: drives the hazy pixel and observes the recovered one.
    modport master (
        output i_data_valid, i_vs, i_hs, i_r, i_g, i_b, i_transmittance, i_atmos,
        input  o_r, o_g, o_b, o_data_valid, o_vs, o_hs, o_atmos_used
    );

    // Recovery stage side.
    modport slave (
        input  i_data_valid, i_vs, i_hs, i_r, i_g, i_b, i_transmittance, i_atmos,
        output o_r, o_g, o_b, o_data_valid, o_vs, o_hs, o_atmos_used
    );
endinterface

// File: rtl/dcp_recover.sv
// Dark-channel-prior scene recovery: J = (I - A) / t + A per RGB channel.
// The pipeline has four stages: reciprocal ROM, difference, multiply/add and saturate.
// Valid and the syncs travel through a matching delay line.
// A is latched once per frame on the rising edge of i_vs.
// LATENCY documents the datapath depth and must stay 4.
module dcp_recover #(
    parameter logic [7:0] T0      = 8'd26,
    parameter logic [7:0] A_MIN   = 8'd160,
    parameter int         LATENCY = 4
) (
    input  logic         pixelclk,
    input  logic         reset_n,
    dcp_recover_if.slave px
);

    logic [7:0]         in_rgb   [3];
    logic [11:0]        recip_rom [256];

    logic [7:0]         a_reg;
    logic               vs_d;
    logic               vs_rise;

    logic [7:0]         rgb_s1   [3];
    logic [11:0]        recip_s1;
    logic [7:0]         a_s1;

    logic signed [8:0]  diff_s2  [3];
    logic [11:0]        recip_s2;
    logic [7:0]         a_s2;

    logic signed [21:0] prod     [3];
    logic signed [15:0] sum_c    [3];
    logic signed [15:0] sum_s3   [3];

    logic [7:0]         out_q    [3];

    logic [LATENCY-1:0] v_dly;
    logic [LATENCY-1:0] vs_dly;
    logic [LATENCY-1:0] hs_dly;

    assign in_rgb[0] = px.i_r;
    assign in_rgb[1] = px.i_g;
    assign in_rgb[2] = px.i_b;

    // Reciprocal table floor(65280 / max(t, T0)); entries below T0 hold the clamped value.
    for (genvar gi = 0; gi < 256; gi++) begin : g_rom
        localparam int TC = (gi < int'(T0)) ? int'(T0) : gi;
        assign recip_rom[gi] = 12'(65280 / TC);
    end

    assign vs_rise = px.i_vs & ~vs_d;

    // Frame A register: floored at A_MIN and loaded only on the rising edge of i_vs.
    always_ff @(posedge pixelclk) begin
        if (!reset_n) begin
            a_reg <= '0;
            vs_d  <= 1'b0;
        end else begin
            vs_d <= px.i_vs;
            if (vs_rise) begin
                a_reg <= (px.i_atmos < A_MIN) ? A_MIN : px.i_atmos;
            end
        end
    end

    // Valid and sync delay lines, one bit per pipeline stage.
    always_ff @(posedge pixelclk) begin
        if (!reset_n) begin
            v_dly  <= '0;
            vs_dly <= '0;
            hs_dly <= '0;
        end else begin
            v_dly  <= {v_dly[LATENCY-2:0],  px.i_data_valid};
            vs_dly <= {vs_dly[LATENCY-2:0], px.i_vs};
            hs_dly <= {hs_dly[LATENCY-2:0], px.i_hs};
        end
    end

    // Stage 3 arithmetic: signed product, floor shift by 8, and A added back.
    always_comb begin
        for (int c = 0; c < 3; c++) begin
            prod[c]  = 22'(diff_s2[c]) * 22'($signed({1'b0, recip_s2}));
            // prod[21:8] is prod >>> 8; the sign is extended to 16 bits before adding A.
            sum_c[c] = {{2{prod[c][21]}}, prod[c][21:8]} + {8'd0, a_s2};
        end
    end

    // Pipeline stages 1 to 4.
    // A is carried along with each pixel, so a pixel sampled on the vs edge keeps the old A.
    always_ff @(posedge pixelclk) begin
        if (!reset_n) begin
            recip_s1 <= '0;
            a_s1     <= '0;
            recip_s2 <= '0;
            a_s2     <= '0;
            for (int c = 0; c < 3; c++) begin
                rgb_s1[c]  <= '0;
                diff_s2[c] <= '0;
                sum_s3[c]  <= '0;
                out_q[c]   <= '0;
            end
        end else begin
            recip_s1 <= recip_rom[px.i_transmittance];
            a_s1     <= a_reg;
            recip_s2 <= recip_s1;
            a_s2     <= a_s1;
            for (int c = 0; c < 3; c++) begin
                rgb_s1[c]  <= in_rgb[c];
                diff_s2[c] <= $signed({1'b0, rgb_s1[c]}) - $signed({1'b0, a_s1});
                sum_s3[c]  <= sum_c[c];
                if (!v_dly[LATENCY-2]) begin
                    out_q[c] <= '0;
                end else if (sum_s3[c] < 16'sd0) begin
                    out_q[c] <= '0;
                end else if (sum_s3[c] > 16'sd255) begin
                    out_q[c] <= 8'd255;
                end else begin
                    out_q[c] <= sum_s3[c][7:0];
                end
            end
        end
    end

    assign px.o_r          = out_q[0];
    assign px.o_g          = out_q[1];
    assign px.o_b          = out_q[2];
    assign px.o_data_valid = v_dly[LATENCY-1];
    assign px.o_vs         = vs_dly[LATENCY-1];
    assign px.o_hs         = hs_dly[LATENCY-1];
    assign px.o_atmos_used = a_reg;

endmodule

// File: tb/tb_dcp_recover.sv
// Bench for dcp_recover.
// Directed pixels are checked against hand-computed values.
// A random stream is checked every cycle against an arithmetic reference and an expected queue.
module tb_dcp_recover;

    localparam int W   = 27;   // {valid, vs, hs, r, g, b}
    localparam int LAT = 4;

    logic pixelclk;
    logic reset_n;

    dcp_recover_if bus ();

    dcp_recover dut (
        .pixelclk (pixelclk),
        .reset_n  (reset_n),
        .px       (bus)
    );

    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_obs;
    logic [7:0]   a_model;
    logic         vs_prev;
    int           n_cmp;
    int           n_err;

    // Clock and reset defaults.
    initial begin
        pixelclk = 1'b0;
        forever #5 pixelclk = ~pixelclk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference recovery for one channel, computed with plain integer arithmetic.
    function automatic logic [7:0] ref_chan(input int i, input int a, input int t);
        int tc;
        int recip;
        int prod;
        int s;
        int sum;
        tc    = (t < 26) ? 26 : t;
        recip = 65280 / tc;
        prod  = (i - a) * recip;
        s     = (prod >= 0) ? prod / 256 : -((-prod + 255) / 256);
        sum   = s + a;
        if (sum < 0) return 8'd0;
        if (sum > 255) return 8'd255;
        return 8'(sum);
    endfunction

    // Drive one cycle of input, advance the model, and compare the output leaving the pipe.
    task automatic step(input logic v, input logic vs, input logic hs,
                        input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                        input logic [7:0] t, input logic [7:0] atmos);
        logic [W-1:0] e;
        logic [W-1:0] o;
        bus.i_data_valid    = v;
        bus.i_vs            = vs;
        bus.i_hs            = hs;
        bus.i_r             = r;
        bus.i_g             = g;
        bus.i_b             = b;
        bus.i_transmittance = t;
        bus.i_atmos         = atmos;
        if (v) e = {v, vs, hs, ref_chan(int'(r), int'(a_model), int'(t)),
                    ref_chan(int'(g), int'(a_model), int'(t)),
                    ref_chan(int'(b), int'(a_model), int'(t))};
        else   e = {1'b0, vs, hs, 24'd0};
        exp_q.push_back(e);
        if (vs && !vs_prev) a_model = (atmos < 8'd160) ? 8'd160 : atmos;
        vs_prev = vs;
        @(posedge pixelclk);
        #1;
        o = {bus.o_data_valid, bus.o_vs, bus.o_hs, bus.o_r, bus.o_g, bus.o_b};
        last_obs = o;
        check("pixel", 32'(o), 32'(exp_q.pop_front()));
        check("atmos_used", 32'(bus.o_atmos_used), 32'(a_model));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd0);
    endtask

    task automatic frame_start(input logic [7:0] atmos);
        step(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 8'd255, atmos);
        step(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd255, atmos);
    endtask

    // A single valid pixel followed by enough idle cycles for it to reach the outputs.
    task automatic pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                         input logic [7:0] t);
        step(1'b1, 1'b0, 1'b0, r, g, b, t, 8'd0);
        idle(LAT - 1);
    endtask

    task automatic check_rgb(input string tag, input logic [7:0] r, input logic [7:0] g,
                             input logic [7:0] b);
        check({tag, "_valid"}, 32'(last_obs[26]), 32'd1);
        check({tag, "_r"}, 32'(last_obs[23:16]), 32'(r));
        check({tag, "_g"}, 32'(last_obs[15:8]), 32'(g));
        check({tag, "_b"}, 32'(last_obs[7:0]), 32'(b));
    endtask

    // Apply reset with a valid pixel on the bus, check the cleared outputs, then reseed the model.
    task automatic apply_reset(input int cycles);
        reset_n             = 1'b0;
        bus.i_data_valid    = 1'b1;
        bus.i_vs            = 1'b1;
        bus.i_hs            = 1'b1;
        bus.i_r             = 8'($urandom_range(0, 255));
        bus.i_g             = 8'($urandom_range(0, 255));
        bus.i_b             = 8'($urandom_range(0, 255));
        bus.i_transmittance = 8'd255;
        bus.i_atmos         = 8'd200;
        repeat (cycles) @(posedge pixelclk);
        #1;
        check("rst_valid", 32'(bus.o_data_valid), 32'd0);
        check("rst_vs", 32'(bus.o_vs), 32'd0);
        check("rst_hs", 32'(bus.o_hs), 32'd0);
        check("rst_rgb", 32'({bus.o_r, bus.o_g, bus.o_b}), 32'd0);
        check("rst_atmos", 32'(bus.o_atmos_used), 32'd0);
        reset_n = 1'b1;
        exp_q.delete();
        for (int k = 0; k < LAT - 1; k++) exp_q.push_back('0);
        a_model = 8'd0;
        vs_prev = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        apply_reset(2);

        // Pipeline drains with zeros after reset, and A reads 0 before any vs edge.
        idle(2);
        check("pre_frame_a", 32'(bus.o_atmos_used), 32'd0);

        // With t = 255 the reciprocal is 256, so the output equals the input.
        frame_start(8'd200);
        check("a_latch_200", 32'(bus.o_atmos_used), 32'd200);
        pixel(8'd37, 8'd128, 8'd250, 8'd255);
        check_rgb("identity", 8'd37, 8'd128, 8'd250);

        // t = 128 gives recip 510; R: -20*510 >>> 8 = -40, so 220 - 40 = 180.
        frame_start(8'd220);
        pixel(8'd200, 8'd220, 8'd0, 8'd128);
        check_rgb("nominal", 8'd180, 8'd220, 8'd0);

        // t = 10 is clamped to 26 (recip 2510). G: 2510 >>> 8 = 9, so 240 + 9 = 249.
        frame_start(8'd240);
        pixel(8'd0, 8'd241, 8'd240, 8'd10);
        check_rgb("clamp", 8'd0, 8'd249, 8'd240);

        // i_atmos = 100 is floored to 160. G saturates high; B: 160 + 9 = 169.
        frame_start(8'd100);
        check("a_floor_100", 32'(bus.o_atmos_used), 32'd160);
        pixel(8'd100, 8'd255, 8'd161, 8'd10);
        check_rgb("saturate", 8'd0, 8'd255, 8'd169);

        // Floor again, then a mid-frame change of i_atmos that must be ignored.
        frame_start(8'd90);
        check("a_floor_90", 32'(bus.o_atmos_used), 32'd160);
        step(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd50);
        step(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd250);
        check("a_hold", 32'(bus.o_atmos_used), 32'd160);

        // A pixel on the vs edge keeps the old A (160): 160 + 79 = 239.
        // The following pixel uses the new A (240): 240 - 80 = 160.
        step(1'b1, 1'b1, 1'b0, 8'd200, 8'd200, 8'd200, 8'd128, 8'd240);
        check("a_new_240", 32'(bus.o_atmos_used), 32'd240);
        step(1'b1, 1'b1, 1'b0, 8'd200, 8'd200, 8'd200, 8'd128, 8'd240);
        step(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd0);
        step(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd0);
        check_rgb("edge_old_a", 8'd239, 8'd239, 8'd239);
        step(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd0);
        check_rgb("after_edge_new_a", 8'd160, 8'd160, 8'd160);

        // Random stream with valid gaps, hs pulses and vs frames.
        // A one-cycle reset lands inside a valid burst.
        for (int i = 0; i < 1000; i++) begin
            logic v;
            logic vs;
            logic hs;
            if (i == 500) apply_reset(1);
            v  = (i >= 490 && i < 500) ? 1'b1 : ($urandom_range(0, 3) != 0);
            vs = ((i % 150) < 2);
            hs = ($urandom_range(0, 15) == 0);
            step(v, vs, hs, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 8'($urandom_range(0, 255)),
                 ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 30)) : 8'($urandom_range(0, 255)),
                 8'($urandom_range(0, 255)));
        end
        idle(LAT);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
